mole_popup_animator: RTL and testbench
======================================

Name: mole_popup_animator

Overview:
- Drives the pop-up and pop-down animation of the active mole and returns `popup_done` to the game-state FSM.
- Decodes the FSM's `display_state` and advances the sprite height on each video frame tick.
- Exports height, sprite selection and hole index to the video renderer.
- Closes the MOLE_ASCENDING (13), HAPPY_MOLE_DESCENDING (14) and DEAD_MOLE_DESCENDING (15) handshakes.

Parameters:
- MAX_HEIGHT, 6'd48, fully-raised sprite height in pixels.
- STEP, 6'd4, pixels moved per frame tick.
- DEAD_PAUSE, 4'd8, frame ticks the dead sprite stays fully shown before it descends.

Ports:
- clk  in  1  system clock (27 MHz).
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- display_state  in  4  game FSM state code.
- mole_location  in  3  hole index from the FSM; sampled on start of ascend.
- frame_tick  in  1  one-cycle pulse per video frame.
- popup_done  out  1  one-cycle pulse when an ascend or descend completes.
- mole_height  out  6  current sprite height in pixels.
- mole_visible  out  1  high while mole_height != 0 or state != IDLE.
- sprite_sel  out  2  0 none, 1 normal, 2 happy, 3 dead.
- active_hole  out  3  latched hole index.

Behaviour:
- All outputs are registered. Reset values: popup_done 0, mole_height 0, mole_visible 0, sprite_sel 0, active_hole 0, state IDLE, pause counter 0.

States and transitions:
- IDLE:
  - display_state==13 -> ASCEND.
  - On that transition: active_hole<=mole_location, sprite_sel<=1, mole_height<=0.
- ASCEND:
  - On frame_tick: mole_height <= min(mole_height+STEP, MAX_HEIGHT). Compute the sum at 7 bits, then saturate.
  - When the updated height equals MAX_HEIGHT: popup_done=1 on the same edge, -> HOLD.
  - display_state != 13 before completion (misstep/whack abort): -> HOLD with height frozen, no popup_done.
- HOLD:
  - Height constant.
  - display_state==14 -> DESCEND, sprite_sel<=2.
  - display_state==15 -> PAUSE, sprite_sel<=3, pause counter<=0.
- PAUSE:
  - Counts frame_ticks.
  - When the counter reaches DEAD_PAUSE -> DESCEND, sprite_sel stays 3.
- DESCEND:
  - On frame_tick: if mole_height <= STEP, then mole_height<=0, popup_done=1, sprite_sel<=0, -> IDLE.
  - Otherwise mole_height -= STEP.
  - Entering at height 0 still waits for one frame_tick before popup_done.
- From any state, display_state==0 (IDLE) or 8 (GAME_OVER) -> IDLE immediately:
  - mole_height<=0, sprite_sel<=0.
  - No popup_done.

Rules and boundary conditions:
- A frame_tick in the same cycle as a state-entry transition is ignored; the first movement happens on the next tick.
- popup_done is exactly one cycle wide and never asserted in two consecutive cycles.
- mole_visible = (mole_height != 0) || (state != IDLE). It is registered alongside the height.
- display_state==13 seen outside IDLE is ignored. A new ascend requires a prior return to IDLE.
- reset mid-animation returns to reset values on the next edge, regardless of frame_tick or display_state.
- If STEP == 0 the mole never moves. This configuration is illegal; the bench does not exercise it.

Test Plan:
- Normal ascend. display_state=13, 12 frame_ticks (default params) -> height 4,8,…,48; popup_done pulses once on the 12th tick edge; sprite_sel=1; active_hole=mole_location captured at entry (e.g. 5).
- Happy descend. After full ascend, display_state=4 then 14, 12 ticks -> height 44…0; popup_done on 12th tick; sprite_sel 2 then 0; state IDLE, mole_visible 0.
- Dead descend with pause. From HOLD at 48, display_state=15 -> sprite_sel=3.
  - Height stays 48 for 8 ticks, then 12 descend ticks.
  - popup_done fires only at height 0; total 20 ticks.
- Abort mid-ascend. display_state 13 for 5 ticks (height 20), then 5 -> height frozen at 20, no popup_done.
  - Then display_state=14 -> 5 ticks to 0, popup_done once.
- Saturation. MAX_HEIGHT=50, STEP=4 -> 13th tick clamps to 50 (not 52) and popup_done fires on that tick.
- Reset and forced idle.
  - reset asserted at height 24 during ASCEND -> next cycle all outputs 0, no popup_done.
  - Separately, display_state=8 during PAUSE -> IDLE, height 0, no popup_done.
  - A frame_tick coincident with entry to ASCEND leaves the height at 0.

Source files
------------

// File: rtl/mole_popup_animator.sv
// mole_popup_animator
// Animates the active mole's sprite height up and down on video frame ticks,
// following the game FSM's display_state, and pulses popup_done back to the
// FSM when an ascend or descend animation completes.
module mole_popup_animator #(
  parameter logic [5:0] MAX_HEIGHT = 6'd48,
  parameter logic [5:0] STEP       = 6'd4,
  parameter logic [3:0] DEAD_PAUSE = 4'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] display_state,
  input  logic [2:0] mole_location,
  input  logic       frame_tick,
  output logic       popup_done,
  output logic [5:0] mole_height,
  output logic       mole_visible,
  output logic [1:0] sprite_sel,
  output logic [2:0] active_hole
);

  // Animator states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ASCEND  = 3'd1;
  localparam logic [2:0] ST_HOLD    = 3'd2;
  localparam logic [2:0] ST_PAUSE   = 3'd3;
  localparam logic [2:0] ST_DESCEND = 3'd4;

  // Game FSM state codes this block reacts to
  localparam logic [3:0] DS_IDLE      = 4'd0;
  localparam logic [3:0] DS_GAME_OVER = 4'd8;
  localparam logic [3:0] DS_ASCEND    = 4'd13;
  localparam logic [3:0] DS_HAPPY     = 4'd14;
  localparam logic [3:0] DS_DEAD      = 4'd15;

  // Sprite codes
  localparam logic [1:0] SPR_NONE   = 2'd0;
  localparam logic [1:0] SPR_NORMAL = 2'd1;
  localparam logic [1:0] SPR_HAPPY  = 2'd2;
  localparam logic [1:0] SPR_DEAD   = 2'd3;

  logic [2:0] state_q,     state_d;
  logic [5:0] height_q,    height_d;
  logic [1:0] sprite_q,    sprite_d;
  logic [2:0] hole_q,      hole_d;
  logic [3:0] pause_cnt_q, pause_cnt_d;
  logic       done_q,      done_d;
  logic       visible_q,   visible_d;

  logic [6:0] sum_s;
  logic [5:0] sat_s;
  logic [4:0] pause_inc_s;

  // Saturating height increment (7-bit sum so the carry is never lost) and pause increment
  always_comb begin
    sum_s       = {1'b0, height_q} + {1'b0, STEP};
    pause_inc_s = {1'b0, pause_cnt_q} + 5'd1;
    if (sum_s > {1'b0, MAX_HEIGHT}) begin
      sat_s = MAX_HEIGHT;
    end else begin
      sat_s = sum_s[5:0];
    end
  end

  // Next-state and next-output computation for the animation sequencer
  always_comb begin
    state_d     = state_q;
    height_d    = height_q;
    sprite_d    = sprite_q;
    hole_d      = hole_q;
    pause_cnt_d = pause_cnt_q;
    done_d      = 1'b0;

    if ((display_state == DS_IDLE) || (display_state == DS_GAME_OVER)) begin
      // Game went idle or ended: drop the mole immediately, no handshake
      state_d  = ST_IDLE;
      height_d = 6'd0;
      sprite_d = SPR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (display_state == DS_ASCEND) begin
            state_d  = ST_ASCEND;
            hole_d   = mole_location;
            sprite_d = SPR_NORMAL;
            height_d = 6'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ASCEND: begin
          if (display_state != DS_ASCEND) begin
            // Aborted (misstep / whack) before fully raised: freeze height
            state_d = ST_HOLD;
          end else if (frame_tick) begin
            height_d = sat_s;
            if (sat_s == MAX_HEIGHT) begin
              done_d  = 1'b1;
              state_d = ST_HOLD;
            end else begin
              state_d = ST_ASCEND;
            end
          end else begin
            state_d = ST_ASCEND;
          end
        end
        ST_HOLD: begin
          if (display_state == DS_HAPPY) begin
            state_d  = ST_DESCEND;
            sprite_d = SPR_HAPPY;
          end else if (display_state == DS_DEAD) begin
            state_d     = ST_PAUSE;
            sprite_d    = SPR_DEAD;
            pause_cnt_d = 4'd0;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_PAUSE: begin
          if (frame_tick) begin
            pause_cnt_d = pause_inc_s[3:0];
            if (pause_inc_s == {1'b0, DEAD_PAUSE}) begin
              state_d = ST_DESCEND;
            end else begin
              state_d = ST_PAUSE;
            end
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_DESCEND: begin
          if (frame_tick) begin
            if (height_q <= STEP) begin
              height_d = 6'd0;
              done_d   = 1'b1;
              sprite_d = SPR_NONE;
              state_d  = ST_IDLE;
            end else begin
              height_d = height_q - STEP;
              state_d  = ST_DESCEND;
            end
          end else begin
            state_d = ST_DESCEND;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          height_d = 6'd0;
          sprite_d = SPR_NONE;
        end
      endcase
    end

    visible_d = (height_d != 6'd0) || (state_d != ST_IDLE);
  end

  // State and registered outputs, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      height_q    <= 6'd0;
      sprite_q    <= SPR_NONE;
      hole_q      <= 3'd0;
      pause_cnt_q <= 4'd0;
      done_q      <= 1'b0;
      visible_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      height_q    <= height_d;
      sprite_q    <= sprite_d;
      hole_q      <= hole_d;
      pause_cnt_q <= pause_cnt_d;
      done_q      <= done_d;
      visible_q   <= visible_d;
    end
  end

  assign popup_done   = done_q;
  assign mole_height  = height_q;
  assign mole_visible = visible_q;
  assign sprite_sel   = sprite_q;
  assign active_hole  = hole_q;

endmodule

// File: tb/tb_mole_popup_animator.sv
// Bench for mole_popup_animator: two instances (default params and
// MAX_HEIGHT=50) share stimulus; each is compared every cycle against a
// behavioural model, plus hand-computed pins of both DUT and model.
module tb_mole_popup_animator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [3:0] ds    = 4'd0;
  logic [2:0] loc   = 3'd0;
  logic       ft    = 1'b0;

  logic       d0_done, d0_vis, d1_done, d1_vis;
  logic [5:0] d0_h, d1_h;
  logic [1:0] d0_spr, d1_spr;
  logic [2:0] d0_hole, d1_hole;

  mole_popup_animator u_dut0 (
    .clk(clk), .reset(reset), .display_state(ds), .mole_location(loc), .frame_tick(ft),
    .popup_done(d0_done), .mole_height(d0_h), .mole_visible(d0_vis),
    .sprite_sel(d0_spr), .active_hole(d0_hole)
  );

  mole_popup_animator #(.MAX_HEIGHT(6'd50), .STEP(6'd4), .DEAD_PAUSE(4'd8)) u_dut1 (
    .clk(clk), .reset(reset), .display_state(ds), .mole_location(loc), .frame_tick(ft),
    .popup_done(d1_done), .mole_height(d1_h), .mole_visible(d1_vis),
    .sprite_sel(d1_spr), .active_hole(d1_hole)
  );

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_UP = 1, M_HOLD = 2, M_PAUSE = 3, M_DOWN = 4;

  typedef struct {
    int mode; int h; int spr; int hole; int cnt; int done; int vis;
  } mdl_t;

  mdl_t m0 = '{default: 0};
  mdl_t m1 = '{default: 0};

  function automatic mdl_t mstep(mdl_t m, int d, int l, int t, int r, int maxh, int stp, int pz);
    mdl_t n = m;
    n.done = 0;
    if (r != 0) begin
      n = '{default: 0};
      return n;
    end
    if (d == 0 || d == 8) begin
      n.mode = M_IDLE; n.h = 0; n.spr = 0;
    end else if (m.mode == M_IDLE) begin
      if (d == 13) begin n.mode = M_UP; n.hole = l; n.spr = 1; n.h = 0; end
    end else if (m.mode == M_UP) begin
      if (d != 13) n.mode = M_HOLD;
      else if (t != 0) begin
        n.h = (m.h + stp > maxh) ? maxh : m.h + stp;
        if (n.h == maxh) begin n.done = 1; n.mode = M_HOLD; end
      end
    end else if (m.mode == M_HOLD) begin
      if (d == 14) begin n.mode = M_DOWN; n.spr = 2; end
      else if (d == 15) begin n.mode = M_PAUSE; n.spr = 3; n.cnt = 0; end
    end else if (m.mode == M_PAUSE) begin
      if (t != 0) begin
        n.cnt = m.cnt + 1;
        if (n.cnt == pz) n.mode = M_DOWN;
      end
    end else begin
      if (t != 0) begin
        if (m.h <= stp) begin n.h = 0; n.done = 1; n.spr = 0; n.mode = M_IDLE; end
        else n.h = m.h - stp;
      end
    end
    n.vis = (n.h != 0 || n.mode != M_IDLE) ? 1 : 0;
    return n;
  endfunction

  // Model advances on the same edge as the DUTs
  initial begin
    forever begin
      @(posedge clk);
      m0 = mstep(m0, int'(ds), int'(loc), int'(ft), int'(reset), 48, 4, 8);
      m1 = mstep(m1, int'(ds), int'(loc), int'(ft), int'(reset), 50, 4, 8);
    end
  end

  // ---------------- checking ----------------
  int    checks = 0;
  int    errors = 0;
  bit    chk_en = 1'b0;
  int    lit_seq = 0;
  string lit_nm;
  int    lit_dut, lit_h, lit_d, lit_s, lit_hole;

  task automatic cmp(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: every-cycle model comparison plus pending literal pins
  initial begin
    int seen;
    seen = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp("d0_done", int'(d0_done), m0.done);
        cmp("d0_height", int'(d0_h), m0.h);
        cmp("d0_visible", int'(d0_vis), m0.vis);
        cmp("d0_sprite", int'(d0_spr), m0.spr);
        cmp("d0_hole", int'(d0_hole), m0.hole);
        cmp("d1_done", int'(d1_done), m1.done);
        cmp("d1_height", int'(d1_h), m1.h);
        cmp("d1_visible", int'(d1_vis), m1.vis);
        cmp("d1_sprite", int'(d1_spr), m1.spr);
        cmp("d1_hole", int'(d1_hole), m1.hole);
      end
      if (lit_seq != seen) begin
        seen = lit_seq;
        if (lit_dut == 0) begin
          cmp({lit_nm, "_h"}, int'(d0_h), lit_h);
          cmp({lit_nm, "_done"}, int'(d0_done), lit_d);
          cmp({lit_nm, "_spr"}, int'(d0_spr), lit_s);
          cmp({lit_nm, "_hole"}, int'(d0_hole), lit_hole);
          cmp({lit_nm, "_model_h"}, m0.h, lit_h);
          cmp({lit_nm, "_model_done"}, m0.done, lit_d);
          cmp({lit_nm, "_model_spr"}, m0.spr, lit_s);
        end else begin
          cmp({lit_nm, "_h"}, int'(d1_h), lit_h);
          cmp({lit_nm, "_done"}, int'(d1_done), lit_d);
          cmp({lit_nm, "_spr"}, int'(d1_spr), lit_s);
          cmp({lit_nm, "_hole"}, int'(d1_hole), lit_hole);
          cmp({lit_nm, "_model_h"}, m1.h, lit_h);
          cmp({lit_nm, "_model_done"}, m1.done, lit_d);
          cmp({lit_nm, "_model_spr"}, m1.spr, lit_s);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [3:0] d, input logic [2:0] l, input logic t, input logic r);
    @(negedge clk);
    ds = d; loc = l; ft = t; reset = r;
    @(posedge clk);
    #1;
  endtask

  // n frame ticks, each preceded by a quiet cycle; ends right after the last tick edge
  task automatic ticks(input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      step(d, loc, 1'b0, 1'b0);
      step(d, loc, 1'b1, 1'b0);
    end
  endtask

  task automatic pin(input string nm, input int dut, input int h, input int d, input int s, input int hole);
    lit_nm = nm; lit_dut = dut; lit_h = h; lit_d = d; lit_s = s; lit_hole = hole;
    lit_seq++;
  endtask

  initial begin
    logic [3:0] rd;
    int         hold;
    logic [3:0] ds_tab [0:8];
    ds_tab[0] = 4'd0;  ds_tab[1] = 4'd4;  ds_tab[2] = 4'd5;
    ds_tab[3] = 4'd8;  ds_tab[4] = 4'd13; ds_tab[5] = 4'd13;
    ds_tab[6] = 4'd14; ds_tab[7] = 4'd15; ds_tab[8] = 4'd15;

    repeat (3) step(4'd0, 3'd0, 1'b0, 1'b1);
    chk_en = 1'b1;
    pin("reset", 0, 0, 0, 0, 0);

    // Normal ascend, coincident tick on entry is ignored
    step(4'd13, 3'd5, 1'b1, 1'b0);
    pin("asc_entry", 0, 0, 0, 1, 5);
    ticks(4'd13, 11);
    pin("asc_11", 0, 44, 0, 1, 5);
    ticks(4'd13, 1);
    pin("asc_12", 0, 48, 1, 1, 5);
    step(4'd13, 3'd5, 1'b0, 1'b0);
    pin("sat_12", 1, 48, 0, 1, 5);
    ticks(4'd13, 1);
    pin("sat_13", 1, 50, 1, 1, 5);

    // Happy descend
    step(4'd4, 3'd0, 1'b0, 1'b0);
    step(4'd14, 3'd0, 1'b0, 1'b0);
    pin("happy_entry", 0, 48, 0, 2, 5);
    ticks(4'd14, 11);
    pin("happy_11", 0, 4, 0, 2, 5);
    ticks(4'd14, 1);
    pin("happy_12", 0, 0, 1, 0, 5);
    step(4'd14, 3'd0, 1'b0, 1'b0);
    pin("sat_desc_12", 1, 2, 0, 2, 5);
    ticks(4'd14, 1);
    pin("sat_desc_13", 1, 0, 1, 0, 5);

    // Dead descend with pause
    step(4'd13, 3'd2, 1'b0, 1'b0);
    ticks(4'd13, 13);
    step(4'd15, 3'd2, 1'b0, 1'b0);
    pin("dead_entry", 0, 48, 0, 3, 2);
    ticks(4'd15, 8);
    pin("dead_pause8", 0, 48, 0, 3, 2);
    ticks(4'd15, 11);
    pin("dead_19", 0, 4, 0, 3, 2);
    ticks(4'd15, 1);
    pin("dead_20", 0, 0, 1, 0, 2);
    ticks(4'd15, 1);
    pin("sat_dead_21", 1, 0, 1, 0, 2);

    // Abort mid-ascend
    step(4'd13, 3'd3, 1'b0, 1'b0);
    ticks(4'd13, 5);
    pin("abort_20", 0, 20, 0, 1, 3);
    ticks(4'd5, 3);
    pin("abort_frozen", 0, 20, 0, 1, 3);
    step(4'd14, 3'd3, 1'b0, 1'b0);
    pin("abort_happy", 0, 20, 0, 2, 3);
    ticks(4'd14, 4);
    pin("abort_down4", 0, 4, 0, 2, 3);
    ticks(4'd14, 1);
    pin("abort_down5", 0, 0, 1, 0, 3);

    // Reset mid-animation with a coincident tick
    step(4'd13, 3'd6, 1'b0, 1'b0);
    ticks(4'd13, 6);
    pin("pre_reset", 0, 24, 0, 1, 6);
    step(4'd13, 3'd6, 1'b1, 1'b1);
    pin("reset_mid", 0, 0, 0, 0, 0);
    step(4'd0, 3'd0, 1'b0, 1'b0);

    // Forced idle during pause
    step(4'd13, 3'd1, 1'b0, 1'b0);
    ticks(4'd13, 13);
    step(4'd15, 3'd1, 1'b0, 1'b0);
    ticks(4'd15, 3);
    step(4'd8, 3'd1, 1'b1, 1'b0);
    pin("forced_idle", 0, 0, 0, 0, 1);

    // Randomized phase checked against the model every cycle
    rd = 4'd0;
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 9) == 9) rd = 4'($urandom_range(0, 15));
        else rd = ds_tab[$urandom_range(0, 8)];
        hold = $urandom_range(1, 40);
      end
      hold--;
      step(rd, 3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 499) == 0));
    end

    step(4'd0, 3'd0, 1'b0, 1'b0);
    step(4'd0, 3'd0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
